// File: rtl/jtexterm_vregs.sv
// Video register bank: CPU-written pending copies of the scroll, layer and
// control registers, and an active copy that drives the video outputs. The
// active copy is loaded at vblank start (LATCH_VB = 1) or straight after each
// CPU write (LATCH_VB = 0).
module jtexterm_vregs #(
   parameter bit LATCH_VB = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        LVBL,
   input  logic        gfx_ctrl_cs,
   input  logic        gfx_lyr_cs,
   input  logic [12:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_rnw,
   output logic [7:0]  vregs_dout,
   output logic        flip,
   output logic [2:0]  lyr_en,
   output logic [2:0]  obj_bank,
   output logic [1:0]  prio,
   output logic [8:0]  scr0_x,
   output logic [8:0]  scr1_x,
   output logic [7:0]  scr0_y,
   output logic [7:0]  scr1_y,
   output logic        upd
);

   typedef struct packed {
      logic       flip;
      logic [2:0] lyr_en;
      logic [2:0] obj_bank;
      logic [1:0] prio;
      logic [8:0] scr0_x;
      logic [7:0] scr0_y;
      logic [8:0] scr1_x;
      logic [7:0] scr1_y;
   } vset_t;

   // Power-on register set: everything cleared, all layers enabled.
   function automatic vset_t vset_reset();
      vset_t s;
      s        = '0;
      s.lyr_en = 3'b111;
      return s;
   endfunction

   // Apply one CPU byte write to a register set. Unused bits and addresses
   // are simply dropped.
   function automatic vset_t vset_write(input vset_t s, input logic ctrl,
                                        input logic [2:0] a, input logic [7:0] d);
      vset_t r;
      r = s;
      if (ctrl) begin
         case (a[1:0])
            2'd0: begin
               r.lyr_en = d[3:1];
               r.flip   = d[0];
            end
            2'd1:    r.obj_bank = d[2:0];
            2'd2:    r.prio     = d[1:0];
            default: ;
         endcase
      end else begin
         case (a)
            3'd0:    r.scr0_x[7:0] = d;
            3'd1:    r.scr0_x[8]   = d[0];
            3'd2:    r.scr0_y      = d;
            3'd3:    r.scr1_x[7:0] = d;
            3'd4:    r.scr1_x[8]   = d[0];
            3'd5:    r.scr1_y      = d;
            default: ;
         endcase
      end
      return r;
   endfunction

   // Read-back of one register byte; bits without storage read as 1.
   function automatic logic [7:0] vset_read(input vset_t s, input logic ctrl,
                                            input logic [2:0] a);
      logic [7:0] v;
      v = 8'hFF;
      if (ctrl) begin
         case (a[1:0])
            2'd0:    v = {4'hF, s.lyr_en, s.flip};
            2'd1:    v = {5'h1F, s.obj_bank};
            2'd2:    v = {6'h3F, s.prio};
            default: v = 8'hFF;
         endcase
      end else begin
         case (a)
            3'd0:    v = s.scr0_x[7:0];
            3'd1:    v = {7'h7F, s.scr0_x[8]};
            3'd2:    v = s.scr0_y;
            3'd3:    v = s.scr1_x[7:0];
            3'd4:    v = {7'h7F, s.scr1_x[8]};
            3'd5:    v = s.scr1_y;
            default: v = 8'hFF;
         endcase
      end
      return v;
   endfunction

   // Only the low address bits are decoded; the rest are mirrored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^cpu_addr[12:3];

   logic       any_cs;
   logic       wr_term;
   logic       rd_term;
   logic       commit;
   logic       vb_fall;
   logic       load;
   vset_t      load_src;

   logic       wr_prev_q,   wr_prev_d;
   logic       lvbl_q,      lvbl_d;
   logic       lvbl_prev_q, lvbl_prev_d;
   logic       vb_armed_q,  vb_armed_d;
   logic       upd_q,       upd_d;
   logic [7:0] dout_q,      dout_d;
   vset_t      pend_q,      pend_d;
   vset_t      act_q,       act_d;

   // Access decode: one commit on the rising edge of the write term only.
   always_comb begin
      any_cs  = gfx_ctrl_cs | gfx_lyr_cs;
      wr_term = any_cs & ~cpu_rnw;
      rd_term = any_cs & cpu_rnw;
      commit  = wr_term & ~wr_prev_q;
      wr_prev_d = wr_term;
   end

   // Vblank edge detection. The armed flag needs LVBL seen high after reset,
   // so leaving reset inside vblank cannot look like a fresh 1->0 edge.
   always_comb begin
      lvbl_d      = LVBL;
      lvbl_prev_d = lvbl_q;
      vb_armed_d  = vb_armed_q | LVBL;
      vb_fall     = vb_armed_q & lvbl_prev_q & ~lvbl_q;
   end

   // Pending register writes; ctrl window wins when both selects are high.
   always_comb begin
      pend_d = pend_q;
      if (commit) begin
         pend_d = vset_write(pend_q, gfx_ctrl_cs, cpu_addr[2:0], cpu_dout);
      end
   end

   // Active set load: pre-write pending values at vblank, or the freshly
   // written values right after a commit when not latching on vblank.
   always_comb begin
      load     = 1'b0;
      load_src = pend_q;
      if (LATCH_VB) begin
         load     = vb_fall;
         load_src = pend_q;
      end else begin
         load     = commit;
         load_src = pend_d;
      end
      act_d = load ? load_src : act_q;
      upd_d = load;
   end

   // Registered read-back; idle bus reads as all ones.
   always_comb begin
      dout_d = 8'hFF;
      if (rd_term) begin
         dout_d = vset_read(pend_q, gfx_ctrl_cs, cpu_addr[2:0]);
      end
   end

   // Control state: commit detector starts high so a select held across
   // reset release is not taken as a new access.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_prev_q   <= 1'b1;
         lvbl_q      <= 1'b1;
         lvbl_prev_q <= 1'b1;
         vb_armed_q  <= 1'b0;
         upd_q       <= 1'b0;
         dout_q      <= 8'hFF;
      end else begin
         wr_prev_q   <= wr_prev_d;
         lvbl_q      <= lvbl_d;
         lvbl_prev_q <= lvbl_prev_d;
         vb_armed_q  <= vb_armed_d;
         upd_q       <= upd_d;
         dout_q      <= dout_d;
      end
   end

   // Register file: pending and active copies.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= vset_reset();
         act_q  <= vset_reset();
      end else begin
         pend_q <= pend_d;
         act_q  <= act_d;
      end
   end

   assign vregs_dout = dout_q;
   assign upd        = upd_q;
   assign flip       = act_q.flip;
   assign lyr_en     = act_q.lyr_en;
   assign obj_bank   = act_q.obj_bank;
   assign prio       = act_q.prio;
   assign scr0_x     = act_q.scr0_x;
   assign scr0_y     = act_q.scr0_y;
   assign scr1_x     = act_q.scr1_x;
   assign scr1_y     = act_q.scr1_y;

endmodule

// File: doc/jtexterm_vregs.md
JTEXTERM_VREGS -- requirements
Module: jtexterm_vregs

Interface
REQ-001 Parameter LATCH_VB, default 1: 1 = active registers update only at vblank start; 0 = active registers follow pending registers one cycle after each write.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 LVBL  input  1  vertical blank, active low; same clock domain.
REQ-005 gfx_ctrl_cs  input  1  registered select for the F3xx window, held for the whole CPU access.
REQ-006 gfx_lyr_cs  input  1  registered select for the F4xx window, held for the whole CPU access.
REQ-007 cpu_addr  input  13  CPU address; only bits [2:0] are decoded.
REQ-008 cpu_dout  input  8  CPU write data.
REQ-009 cpu_rnw  input  1  1 = read, 0 = write.
REQ-010 vregs_dout  output  8  registered read-back data.
REQ-011 flip  output  1  active screen flip.
REQ-012 lyr_en  output  3  active layer enables: bit0 = scroll 0, bit1 = scroll 1, bit2 = objects.
REQ-013 obj_bank  output  3  active object bank.
REQ-014 prio  output  2  active layer priority code.
REQ-015 scr0_x / scr1_x  output  9 each  active horizontal scroll.
REQ-016 scr0_y / scr1_y  output  8 each  active vertical scroll.
REQ-017 upd  output  1  one-cycle pulse each cycle the active set is loaded.

Function
REQ-018 The ctrl window shall decode cpu_addr[1:0] and mirror it across the window: 0 = {lyr_en[2:0], flip} on bits [3:0]; 1 = obj_bank on bits [2:0]; 2 = prio on bits [1:0]; 3 = unused (writes ignored).
REQ-019 The layer window shall decode cpu_addr[2:0]: 0 = scr0_x[7:0]; 1 = scr0_x[8] on bit 0; 2 = scr0_y; 3 = scr1_x[7:0]; 4 = scr1_x[8] on bit 0; 5 = scr1_y; 6 and 7 = unused.
REQ-020 Each register shall have a pending copy (written by the CPU) and an active copy (driving the outputs).
REQ-021 Write commit: exactly one commit per access, in the first cycle where (gfx_ctrl_cs | gfx_lyr_cs) & ~cpu_rnw is high and the previous cycle's value of that term was low; cs held high for N cycles shall not produce further commits.
REQ-022 A write commit shall update only the addressed pending register; unused bits and unused addresses are discarded.
REQ-023 Both cs asserted in the same cycle shall be treated as a ctrl-window access only.
REQ-024 Read: when a cs is high and cpu_rnw = 1, vregs_dout shall present the addressed pending value on the next cycle, with unused bits read as 1 and unused addresses read as 8'hFF.
REQ-025 When no cs is high, vregs_dout shall hold 8'hFF from the next cycle.
REQ-026 With LATCH_VB = 1, the block shall register LVBL, detect a 1->0 transition, and on the following cycle copy every pending register to its active copy and pulse upd.
REQ-027 A write commit in the same cycle as the vblank load shall update its pending register. The active copy shall receive the pending value from before the write, so the new value reaches the outputs at the next vblank.
REQ-028 Writes while LVBL = 0 after the load shall stay pending until the next 1->0 edge, with no mid-frame output change.
REQ-029 With LATCH_VB = 0, the active copies shall load from the pending copies one cycle after any write commit, and upd shall pulse in that cycle.
REQ-030 Active outputs shall change only in a cycle where upd = 1.
REQ-031 Scroll values shall be stored exactly as written, with no arithmetic, offset or wrap applied.

Reset
REQ-032 While rst = 1, all pending and active registers shall be 0 except lyr_en = 3'b111, and vregs_dout = 8'hFF, upd = 0.
REQ-033 The LVBL edge detector shall reset to 1, so that rst released while LVBL = 0 produces no upd until a later 1->0 edge.
REQ-034 rst asserted mid-access shall discard the access, and the commit detector shall not fire after release until cs has been seen low for at least one cycle.

Verification
REQ-035 LATCH_VB=1: write 8'h34 to layer addr 0 and 8'h01 to addr 1 with LVBL=1 -> scr0_x stays 0; after LVBL falls, scr0_x = 9'h134 and upd pulses once, 2 cycles after the edge.
REQ-036 Write access holding gfx_lyr_cs for 6 cycles to addr 2 with data 8'h55, then cpu_dout changed to 8'hAA mid-access -> exactly one commit; pending scr0_y = 8'h55.
REQ-037 Write to layer addr 5 coinciding with the vblank load cycle -> pending scr1_y holds the new value; active scr1_y unchanged until the next LVBL fall.
REQ-038 Read ctrl addr 1 after writing 8'hFD -> vregs_dout = 8'hFD one cycle after cs; read layer addr 7 -> 8'hFF; read layer addr 4 after writing 8'h01 -> 8'hFF.
REQ-039 LATCH_VB=0: write ctrl addr 0 = 8'h09 -> one cycle after the commit, flip = 1, lyr_en = 3'b100, upd = 1.
REQ-040 Assert rst mid-frame with LVBL=0 and cs high -> outputs at reset values, lyr_en = 3'b111, no upd and no commit until cs is cycled and LVBL falls again.
